// File: rtl/plab3_mem_line_refill_responder_pkg.sv
// Shared definitions for the line refill responder: message type codes, FSM state
// encoding, beat geometry (beats per line, beat-index width, line-offset shift).
// No ports; imported by plab3_mem_line_beat_reg and plab3_mem_line_refill_responder.
package plab3_mem_line_refill_responder_pkg;

    // Memory message type field widths (request and response share one encoding)
    localparam int MEM_REQ_TYPE_NBITS  = 3;
    localparam int MEM_RESP_TYPE_NBITS = 3;

    localparam logic [MEM_REQ_TYPE_NBITS-1:0] MEM_TYPE_READ       = 3'd0;
    localparam logic [MEM_REQ_TYPE_NBITS-1:0] MEM_TYPE_WRITE      = 3'd1;
    localparam logic [MEM_REQ_TYPE_NBITS-1:0] MEM_TYPE_WRITE_INIT = 3'd2;
    localparam logic [MEM_REQ_TYPE_NBITS-1:0] MEM_TYPE_AMO_ADD    = 3'd3;
    localparam logic [MEM_REQ_TYPE_NBITS-1:0] MEM_TYPE_AMO_AND    = 3'd4;
    localparam logic [MEM_REQ_TYPE_NBITS-1:0] MEM_TYPE_AMO_OR     = 3'd5;
    localparam logic [MEM_REQ_TYPE_NBITS-1:0] MEM_TYPE_PRELW      = 3'd6;

    // Line geometry: 128-bit line made of four 32-bit words, 16-byte aligned
    localparam int LINE_NBEATS    = 4;
    localparam int BEAT_IDX_NBITS = 2;
    localparam int LINE_OFF_SHAMT = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3
    } line_resp_state_t;

    // WRITE and WRITE_INIT push the captured line out; everything else fetches.
    function automatic logic is_write_type(input logic [MEM_REQ_TYPE_NBITS-1:0] t);
        return (t == MEM_TYPE_WRITE) || (t == MEM_TYPE_WRITE_INIT);
    endfunction

    function automatic logic is_amo_type(input logic [MEM_REQ_TYPE_NBITS-1:0] t);
        return (t == MEM_TYPE_AMO_ADD) || (t == MEM_TYPE_AMO_AND) || (t == MEM_TYPE_AMO_OR);
    endfunction

endpackage

// File: rtl/plab3_mem_line_beat_reg.sv
// Line register with per-word write enable and a word-select read port.
// Latency: write visible one cycle after enable; read port is combinational.
// Backpressure: none, the owner decides when to write.
// Ports: clk/reset (async active-high), i_word_we per-word enable, i_line write data
// (word k written from word k), i_rd_idx word select, o_rd_word selected word, o_line whole line.
module plab3_mem_line_beat_reg
    import plab3_mem_line_refill_responder_pkg::*;
#(
    parameter int p_word_nbits = 32,
    parameter int p_nwords     = LINE_NBEATS,
    parameter int p_idx_nbits  = BEAT_IDX_NBITS
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [p_nwords-1:0]                    i_word_we,
    input  logic [p_nwords-1:0][p_word_nbits-1:0]  i_line,
    input  logic [p_idx_nbits-1:0]                 i_rd_idx,
    output logic [p_word_nbits-1:0]                o_rd_word,
    output logic [p_nwords-1:0][p_word_nbits-1:0]  o_line
);

    logic [p_nwords-1:0][p_word_nbits-1:0] r_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line <= '0;
        end else begin
            for (int i = 0; i < p_nwords; i++) begin
                if (i_word_we[i]) begin
                    r_line[i] <= i_line[i];
                end
            end
        end
    end

    assign o_rd_word = r_line[i_rd_idx];
    assign o_line    = r_line;

endmodule

// File: rtl/plab3_mem_line_refill_responder.sv
// Line refill responder: takes one cacheline request, runs it as four word beats on the
// backing-memory port (one outstanding), and returns one line response.
// Latency: 9 cycles accept->memresp_val with zero-wait memory; backpressure on any port stalls the FSM in place.
// Optional build macro: PLAB3_MEM_LINE_RESP_CRITICAL_WORD_FIRST_EN (start at the addressed word and wrap).
// Ports: clk, reset (async active-high), domain (security label, not used by logic),
//   memreq_*  line request (val/rdy, type, opaque, addr, data)
//   memresp_* line response (val/rdy, type, opaque, data)
//   bmemreq_* word request to backing memory (val/rdy, type, addr, data)
//   bmemresp_* word response from backing memory (val/rdy, data)
module plab3_mem_line_refill_responder
    import plab3_mem_line_refill_responder_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int abw            = 32,
    parameter int dbw            = 32,
    parameter int clw            = 128
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           domain,

    input  logic                           memreq_val,
    output logic                           memreq_rdy,
    input  logic [MEM_REQ_TYPE_NBITS-1:0]  memreq_type,
    input  logic [p_opaque_nbits-1:0]      memreq_opaque,
    input  logic [abw-1:0]                 memreq_addr,
    input  logic [clw-1:0]                 memreq_data,

    output logic                           memresp_val,
    input  logic                           memresp_rdy,
    output logic [MEM_RESP_TYPE_NBITS-1:0] memresp_type,
    output logic [p_opaque_nbits-1:0]      memresp_opaque,
    output logic [clw-1:0]                 memresp_data,

    output logic                           bmemreq_val,
    input  logic                           bmemreq_rdy,
    output logic [MEM_REQ_TYPE_NBITS-1:0]  bmemreq_type,
    output logic [abw-1:0]                 bmemreq_addr,
    output logic [dbw-1:0]                 bmemreq_data,

    input  logic                           bmemresp_val,
    output logic                           bmemresp_rdy,
    input  logic [dbw-1:0]                 bmemresp_data
);

    localparam int c_nbeats = clw / dbw;

    line_resp_state_t                  r_state;
    line_resp_state_t                  w_state_next;
    logic [MEM_REQ_TYPE_NBITS-1:0]     r_type;
    logic [p_opaque_nbits-1:0]         r_opaque;
    logic [abw-LINE_OFF_SHAMT-1:0]     r_base;
    logic [BEAT_IDX_NBITS-1:0]         r_beat;
    logic [BEAT_IDX_NBITS-1:0]         r_cnt;
    logic                              r_is_wr;

    logic                              w_accept;
    logic                              w_capture;
    logic                              w_req_is_wr;
    logic [BEAT_IDX_NBITS-1:0]         w_start_beat;
    logic [c_nbeats-1:0]               w_word_we;
    logic [clw-1:0]                    w_line_in;
    logic [clw-1:0]                    w_line;
    logic [dbw-1:0]                    w_rd_word;
    logic                              w_unused_ok;

    // domain only labels the ports; low address bits never reach the backing port
    assign w_unused_ok = ^{domain, memreq_addr[LINE_OFF_SHAMT-1:0]};

`ifdef PLAB3_MEM_LINE_RESP_CRITICAL_WORD_FIRST_EN
    assign w_start_beat = memreq_addr[LINE_OFF_SHAMT-1:2];
`else
    assign w_start_beat = '0;
`endif

    assign w_accept    = memreq_val && memreq_rdy;
    assign w_capture   = bmemresp_val && bmemresp_rdy;
    assign w_req_is_wr = is_write_type(memreq_type);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        memreq_rdy   = 1'b0;
        bmemreq_val  = 1'b0;
        bmemresp_rdy = 1'b0;
        memresp_val  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // reset forces IDLE asynchronously; keep rdy low while it is held
                memreq_rdy = !reset;
                if (memreq_val && !reset) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bmemreq_val = 1'b1;
                if (bmemreq_rdy) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                bmemresp_rdy = 1'b1;
                if (bmemresp_val) begin
                    w_state_next = (r_cnt == BEAT_IDX_NBITS'(c_nbeats - 1)) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request tag and beat counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_type   <= '0;
            r_opaque <= '0;
            r_base   <= '0;
            r_beat   <= '0;
            r_cnt    <= '0;
            r_is_wr  <= 1'b0;
        end else if (w_accept) begin
            r_type   <= memreq_type;
            r_opaque <= memreq_opaque;
            r_base   <= memreq_addr[abw-1:LINE_OFF_SHAMT];
            r_beat   <= w_start_beat;
            r_cnt    <= '0;
            r_is_wr  <= w_req_is_wr;
        end else if (w_capture) begin
            // beat index wraps inside the line; the line base is never touched
            r_beat   <= r_beat + 1'b1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Line storage: holds write data on the way out, assembles read data
    // on the way in. Reads start from a cleared line.
    // ------------------------------------------------------------------
    always_comb begin
        w_word_we = '0;
        w_line_in = {c_nbeats{bmemresp_data}};
        if (w_accept) begin
            w_word_we = '1;
            w_line_in = w_req_is_wr ? memreq_data : '0;
        end else if (w_capture && !r_is_wr) begin
            w_word_we = c_nbeats'(1) << r_beat;
        end
    end

    plab3_mem_line_beat_reg #(
        .p_word_nbits (dbw),
        .p_nwords     (c_nbeats),
        .p_idx_nbits  (BEAT_IDX_NBITS)
    ) u_line (
        .clk       (clk),
        .reset     (reset),
        .i_word_we (w_word_we),
        .i_line    (w_line_in),
        .i_rd_idx  (r_beat),
        .o_rd_word (w_rd_word),
        .o_line    (w_line)
    );

    // ------------------------------------------------------------------
    // Outputs: everything comes from registers, so it is stable while stalled
    // ------------------------------------------------------------------
    assign bmemreq_type   = r_is_wr ? MEM_TYPE_WRITE : MEM_TYPE_READ;
    assign bmemreq_addr   = {r_base, r_beat, 2'b00};
    assign bmemreq_data   = (r_state == ST_ISSUE && r_is_wr) ? w_rd_word : '0;
    assign memresp_type   = r_type;
    assign memresp_opaque = r_opaque;
    assign memresp_data   = r_is_wr ? '0 : w_line;

    // ------------------------------------------------------------------
    // Interface sanity checks (simulation only effect)
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown({memreq_val, memresp_rdy, bmemreq_rdy, bmemresp_val}));
            // AMOs are not supported; they are serviced as plain reads
            if (w_accept) begin
                assert (!is_amo_type(memreq_type));
            end
        end
    end

endmodule
